sw_alloc: RTL and testbench
===========================

SW_ALLOC -- requirements
Module: sw_alloc

Interface
REQ-001 The module SHALL have parameter PORT_N, default 5, meaning the number of router input and output ports.
REQ-002 The module SHALL have parameter PORT_W, default 3, meaning the width of a port index; PORT_W SHALL be at least clog2(PORT_N).
REQ-003 The module SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port req_i, input, PORT_N bits: input i has a flit for the switch this cycle.
REQ-006 The module SHALL have port port_i, input, PORT_N x PORT_W bits: requested output port of input i, valid only when req_i[i]=1.
REQ-007 The module SHALL have port tail_i, input, PORT_N bits: input i's current flit is a tail (single-flit packets assert it on the head).
REQ-008 The module SHALL have port rdy_i, input, PORT_N bits: output j can accept a flit this cycle (any VC ready).
REQ-009 The module SHALL have port grt_o, output, PORT_N x PORT_N bits: grt_o[i][j]=1 means input i drives output j through the crossbar this cycle.
REQ-010 The module SHALL have port lck_o, output, PORT_N bits: output j is locked to a packet owner.
REQ-011 The module SHALL have port err_o, output, 1 bit: sticky flag, a request named an output index >= PORT_N.

Function
REQ-012 Each output j SHALL contain a 2-state FSM (IDLE, LOCKED), an owner register (PORT_W bits) and a round-robin pointer rr[j] (PORT_W bits, range 0..PORT_N-1).
REQ-013 Output j's candidate set SHALL be the inputs i with req_i[i]=1 and port_i[i]=j; requests with port_i >= PORT_N SHALL join no set.
REQ-014 In IDLE, the winner SHALL be the first candidate found scanning i = rr[j], rr[j]+1, ... modulo PORT_N.
REQ-015 grt_o SHALL be combinational from the current state and inputs (0-cycle latency), so the crossbar transfers in the same cycle.
REQ-016 In IDLE, grt_o[winner][j] SHALL be 1 only if rdy_i[j]=1; if rdy_i[j]=0, no grant is issued and state and rr[j] are unchanged.
REQ-017 In LOCKED, grt_o[owner][j] SHALL be 1 iff req_i[owner]=1, port_i[owner]=j and rdy_i[j]=1; other candidates SHALL never be granted j.
REQ-018 A transfer on output j SHALL be defined as any grt_o[i][j]=1.
REQ-019 On an IDLE transfer with tail_i[winner]=0, the next state SHALL be LOCKED with owner=winner.
REQ-020 On an IDLE transfer with tail_i[winner]=1, the next state SHALL remain IDLE.
REQ-021 On every IDLE transfer, rr[j] SHALL be set to (winner+1) mod PORT_N, with wrap from PORT_N-1 to 0.
REQ-022 In LOCKED, a transfer with tail_i[owner]=1 SHALL return the FSM to IDLE next cycle; rr[j] is unchanged.
REQ-023 If the owner drops req_i while LOCKED (a wormhole bubble), the lock SHALL be held and no grant issued for j.
REQ-024 Each input SHALL receive at most one grant per cycle, and each grt_o column SHALL be one-hot or zero.
REQ-025 lck_o[j] SHALL equal 1 iff output j is in LOCKED.
REQ-026 err_o SHALL set when any req_i[i]=1 with port_i[i] >= PORT_N, and hold until reset.

Reset
REQ-027 While rst=1 at a clock edge, every FSM SHALL go to IDLE, every owner and rr[j] SHALL go to 0, and err_o SHALL go to 0.
REQ-028 Reset asserted mid-packet SHALL drop all locks; grt_o SHALL be 0 whenever rst=1.
REQ-029 lck_o SHALL be 0 in the first cycle after reset.

Verification
REQ-030 Scenario (fairness): inputs 1 and 3 request port 2 with tail=1 every cycle and rdy=1 -> grants to output 2 alternate 1,3,1,3; rr[2] alternates 2,4.
REQ-031 Scenario (wormhole lock): input 0 sends a 4-flit packet to port 4 while input 2 also requests port 4 -> lck_o[4]=1 for the body flits; input 2 is granted only in the cycle after input 0's tail transfer.
REQ-032 Scenario (backpressure): rdy_i[1]=0 for 3 cycles while input 4 requests port 1 -> no grant and rr[1] unchanged; the grant appears in the same cycle rdy_i[1] rises.
REQ-033 Scenario (bubble): owner input 3 deasserts req for 2 cycles mid-packet while input 0 requests the same port -> no grant to input 0; lck_o stays 1.
REQ-034 Scenario (reset mid-packet): assert rst while output 0 is LOCKED -> the next cycle shows lck_o=0, rr=0 and err_o=0, and a fresh request from input 0 is granted.
REQ-035 Scenario (illegal port): req_i[2]=1 with port_i[2]=6 -> no grant and err_o=1, held until rst.

Source files
------------

// File: rtl/sw_alloc_if.sv
// Switch-allocator bundle: per-input requests, per-output readiness, crossbar grants.
// Handshake: a flit moves from input i to output j in exactly the cycle grt_o[i][j]=1.
// A grant is only issued when req_i[i]=1 and rdy_i[j]=1 in that same cycle.
interface sw_alloc_if #(
  parameter int PORT_N = 5,
  parameter int PORT_W = 3
);
  logic [PORT_N-1:0]              req_i;
  logic [PORT_N-1:0][PORT_W-1:0]  port_i;
  logic [PORT_N-1:0]              tail_i;
  logic [PORT_N-1:0]              rdy_i;
  logic [PORT_N-1:0][PORT_N-1:0]  grt_o;
  logic [PORT_N-1:0]              lck_o;
  logic                           err_o;
  logic [PORT_N-1:0][PORT_W-1:0]  dbg_rr_o;
  logic [PORT_N-1:0][PORT_W-1:0]  dbg_owner_o;

  modport master (
    output req_i, port_i, tail_i, rdy_i,
    input  grt_o, lck_o, err_o, dbg_rr_o, dbg_owner_o
  );

  modport slave (
    input  req_i, port_i, tail_i, rdy_i,
    output grt_o, lck_o, err_o, dbg_rr_o, dbg_owner_o
  );
endinterface

// File: rtl/sw_alloc.sv
// Wormhole switch allocator: per-output round-robin arbitration with a packet lock
// held from head to tail. Per-output FSM state is visible on lck_o, rr/owner on dbg_*.
module sw_alloc #(
  parameter int PORT_N = 5,
  parameter int PORT_W = 3
) (
  input  logic      clk,
  input  logic      rst,
  sw_alloc_if.slave bus
);

  localparam logic [0:0]        ST_IDLE   = 1'b0;
  localparam logic [0:0]        ST_LOCKED = 1'b1;
  localparam logic [PORT_W-1:0] LAST_IDX  = PORT_W'(PORT_N - 1);

  logic [PORT_N-1:0]             r_state;
  logic [PORT_N-1:0][PORT_W-1:0] r_owner;
  logic [PORT_N-1:0][PORT_W-1:0] r_rr;
  logic                          r_err;

  // w_cand[j][i]: input i currently asks for output j
  logic [PORT_N-1:0][PORT_N-1:0] w_cand;
  logic                          w_bad;
  logic [PORT_N-1:0][PORT_W-1:0] w_win;
  logic [PORT_N-1:0]             w_found;
  logic [PORT_N-1:0][PORT_N-1:0] w_grt;
  logic [PORT_N-1:0]             w_xfer;

  always_comb begin
    w_cand = '0;
    w_bad  = 1'b0;
    for (int i = 0; i < PORT_N; i++) begin
      for (int j = 0; j < PORT_N; j++) begin
        if (bus.req_i[i] && (bus.port_i[i] == PORT_W'(j))) begin
          w_cand[j][i] = 1'b1;
        end
      end
      if (bus.req_i[i] && ({1'b0, bus.port_i[i]} >= (PORT_W+1)'(PORT_N))) begin
        w_bad = 1'b1;
      end
    end
  end

  // Round-robin scan starting at rr[j]; the first candidate found wins.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = '0;
    w_win   = '0;
    for (int j = 0; j < PORT_N; j++) begin
      for (int k = 0; k < PORT_N; k++) begin
        idx = int'(r_rr[j]) + k;
        if (idx >= PORT_N) begin
          idx = idx - PORT_N;
        end
        if (!w_found[j] && w_cand[j][idx]) begin
          w_found[j] = 1'b1;
          w_win[j]   = PORT_W'(idx);
        end
      end
    end
  end

  // A locked output only ever serves its owner; a bubble simply issues no grant.
  always_comb begin
    w_grt  = '0;
    w_xfer = '0;
    for (int j = 0; j < PORT_N; j++) begin
      if (r_state[j] == ST_IDLE) begin
        if (w_found[j] && bus.rdy_i[j]) begin
          w_grt[w_win[j]][j] = 1'b1;
        end
      end else begin
        if (w_cand[j][r_owner[j]] && bus.rdy_i[j]) begin
          w_grt[r_owner[j]][j] = 1'b1;
        end
      end
    end
    if (rst) begin
      w_grt = '0;
    end
    for (int j = 0; j < PORT_N; j++) begin
      for (int i = 0; i < PORT_N; i++) begin
        w_xfer[j] = w_xfer[j] | w_grt[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_owner <= '0;
      r_rr    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= r_err | w_bad;
      for (int j = 0; j < PORT_N; j++) begin
        if (w_xfer[j]) begin
          if (r_state[j] == ST_IDLE) begin
            r_rr[j] <= (w_win[j] == LAST_IDX) ? '0 : w_win[j] + PORT_W'(1);
            if (!bus.tail_i[w_win[j]]) begin
              r_state[j] <= ST_LOCKED;
              r_owner[j] <= w_win[j];
            end
          end else if (bus.tail_i[r_owner[j]]) begin
            r_state[j] <= ST_IDLE;
          end
        end
      end
    end
  end

  assign bus.grt_o       = w_grt;
  assign bus.lck_o       = r_state;
  assign bus.err_o       = r_err;
  assign bus.dbg_rr_o    = r_rr;
  assign bus.dbg_owner_o = r_owner;

endmodule

// File: tb/tb_sw_alloc.sv
// Bench for sw_alloc: directed scenarios plus random traffic against a packet-level
// model of per-output locks, round-robin pointers and the sticky error flag.
module tb_sw_alloc;
  localparam int N = 5;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sw_alloc_if #(.PORT_N(N), .PORT_W(W)) bus();
  sw_alloc #(.PORT_N(N), .PORT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;
  logic [N*N-1:0] exp_q[$];

  logic m_lock[N];
  int   m_owner[N];
  int   m_rr[N];
  logic m_err;

  function automatic logic [N-1:0] m_lck_vec();
    logic [N-1:0] v;
    for (int j = 0; j < N; j++) v[j] = m_lock[j];
    return v;
  endfunction

  function automatic logic [N-1:0][W-1:0] m_rr_vec();
    logic [N-1:0][W-1:0] v;
    for (int j = 0; j < N; j++) v[j] = W'(m_rr[j]);
    return v;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_lock[j] = 1'b0; m_owner[j] = 0; m_rr[j] = 0;
    end
    m_err = 1'b0;
  endtask

  // Who may use output j now: the lock owner, else the first requester from rr[j].
  task automatic model_expect();
    logic [N*N-1:0] eg;
    eg = '0;
    if (!rst) begin
      for (int j = 0; j < N; j++) begin
        if (!bus.rdy_i[j]) continue;
        if (m_lock[j]) begin
          if (bus.req_i[m_owner[j]] && int'(bus.port_i[m_owner[j]]) == j) eg[m_owner[j]*N+j] = 1'b1;
        end else begin
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr[j] + k) % N;
            if (bus.req_i[i] && int'(bus.port_i[i]) == j) begin
              eg[i*N+j] = 1'b1;
              break;
            end
          end
        end
      end
    end
    exp_q.push_back(eg);
  endtask

  task automatic model_update(input logic [N*N-1:0] eg);
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++)
      if (bus.req_i[i] && int'(bus.port_i[i]) >= N) m_err = 1'b1;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if (!eg[i*N+j]) continue;
        if (!m_lock[j]) begin
          m_rr[j] = (i + 1) % N;
          if (!bus.tail_i[i]) begin m_lock[j] = 1'b1; m_owner[j] = i; end
        end else if (bus.tail_i[i]) begin
          m_lock[j] = 1'b0;
        end
      end
    end
  endtask

  task automatic step(output logic [N*N-1:0] e);
    #1;
    model_expect();
    e = exp_q.pop_front();
  endtask

  task automatic advance(input logic [N*N-1:0] e);
    @(posedge clk);
    model_update(e);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_i = '0; bus.port_i = '0; bus.tail_i = '0; bus.rdy_i = '1;
  endtask

  task automatic set_req(input int i, input logic r, input int p, input logic t);
    bus.req_i[i] = r; bus.port_i[i] = W'(p); bus.tail_i[i] = t;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    set_req(0, 1'b1, 0, 1'b0);
    #1;
    checks++;
    if (bus.grt_o !== '0) begin failures++; $display("FAIL reset_grt got=%h exp=0", bus.grt_o); end
    @(posedge clk);
    model_reset();
    #1;
    checks++;
    if (bus.lck_o !== '0 || bus.err_o !== 1'b0 || bus.dbg_rr_o !== '0) begin
      failures++; $display("FAIL reset_state got lck=%h err=%b rr=%h exp 0", bus.lck_o, bus.err_o, bus.dbg_rr_o);
    end
    rst = 1'b0;
    begin
      logic [N*N-1:0] e;
      step(e);
      checks++;
      if (bus.grt_o !== e) begin failures++; $display("FAIL reset_first_grant got=%h exp=%h", bus.grt_o, e); end
      checks++;
      if (bus.lck_o !== '0) begin failures++; $display("FAIL reset_first_lck got=%h exp=0", bus.lck_o); end
      advance(e);
    end
  endtask

  task automatic test_fairness();
    logic [N*N-1:0] e;
    int win;
    apply_reset();
    set_req(1, 1'b1, 2, 1'b1);
    set_req(3, 1'b1, 2, 1'b1);
    for (int c = 0; c < 6; c++) begin
      win = (c % 2 == 0) ? 1 : 3;
      step(e);
      checks++;
      if (bus.grt_o !== e) begin failures++; $display("FAIL fair_grt c=%0d got=%h exp=%h", c, bus.grt_o, e); end
      checks++;
      if (bus.grt_o[win][2] !== 1'b1) begin failures++; $display("FAIL fair_winner c=%0d got=%h exp_input=%0d", c, bus.grt_o, win); end
      advance(e);
      checks++;
      if (bus.dbg_rr_o[2] !== W'(win + 1)) begin failures++; $display("FAIL fair_rr c=%0d got=%0d exp=%0d", c, bus.dbg_rr_o[2], win + 1); end
    end
  endtask

  task automatic test_wormhole();
    logic [N*N-1:0] e;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      set_req(0, c < 4, 4, c == 3);
      set_req(2, 1'b1, 4, 1'b1);
      step(e);
      checks++;
      if (bus.grt_o !== e) begin failures++; $display("FAIL worm_grt c=%0d got=%h exp=%h", c, bus.grt_o, e); end
      checks++;
      if (bus.grt_o[2][4] !== (c == 4)) begin failures++; $display("FAIL worm_in2 c=%0d got=%b exp=%b", c, bus.grt_o[2][4], c == 4); end
      advance(e);
      checks++;
      if (bus.lck_o[4] !== (c < 3)) begin failures++; $display("FAIL worm_lck c=%0d got=%b exp=%b", c, bus.lck_o[4], c < 3); end
    end
  endtask

  task automatic test_backpressure();
    logic [N*N-1:0] e;
    apply_reset();
    set_req(2, 1'b1, 1, 1'b1);
    step(e);
    advance(e);
    set_req(2, 1'b0, 0, 1'b0);
    set_req(4, 1'b1, 1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      bus.rdy_i[1] = (c == 3);
      step(e);
      checks++;
      if (bus.grt_o !== e) begin failures++; $display("FAIL bp_grt c=%0d got=%h exp=%h", c, bus.grt_o, e); end
      checks++;
      if (bus.grt_o[4][1] !== (c == 3)) begin failures++; $display("FAIL bp_in4 c=%0d got=%b exp=%b", c, bus.grt_o[4][1], c == 3); end
      advance(e);
      checks++;
      if (bus.dbg_rr_o[1] !== ((c == 3) ? W'(0) : W'(3))) begin
        failures++; $display("FAIL bp_rr c=%0d got=%0d exp=%0d", c, bus.dbg_rr_o[1], (c == 3) ? 0 : 3);
      end
    end
  endtask

  task automatic test_bubble();
    logic [N*N-1:0] e;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      set_req(3, (c < 2) || (c == 4), 2, c == 4);
      set_req(0, c >= 1, 2, 1'b1);
      step(e);
      checks++;
      if (bus.grt_o !== e) begin failures++; $display("FAIL bubble_grt c=%0d got=%h exp=%h", c, bus.grt_o, e); end
      checks++;
      if (bus.grt_o[0][2] !== (c == 5)) begin failures++; $display("FAIL bubble_in0 c=%0d got=%b exp=%b", c, bus.grt_o[0][2], c == 5); end
      advance(e);
      checks++;
      if (bus.lck_o[2] !== (c < 4)) begin failures++; $display("FAIL bubble_lck c=%0d got=%b exp=%b", c, bus.lck_o[2], c < 4); end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [N*N-1:0] e;
    apply_reset();
    set_req(1, 1'b1, 0, 1'b0);
    step(e);
    advance(e);
    checks++;
    if (bus.lck_o[0] !== 1'b1) begin failures++; $display("FAIL rstmid_locked got=%b exp=1", bus.lck_o[0]); end
    rst = 1'b1;
    step(e);
    checks++;
    if (bus.grt_o !== '0) begin failures++; $display("FAIL rstmid_grt got=%h exp=0", bus.grt_o); end
    advance(e);
    rst = 1'b0;
    checks++;
    if (bus.lck_o !== '0 || bus.dbg_rr_o !== '0 || bus.err_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_state got lck=%h rr=%h err=%b exp 0", bus.lck_o, bus.dbg_rr_o, bus.err_o);
    end
    set_req(1, 1'b0, 0, 1'b0);
    set_req(0, 1'b1, 0, 1'b1);
    step(e);
    checks++;
    if (bus.grt_o[0][0] !== 1'b1 || bus.grt_o !== e) begin failures++; $display("FAIL rstmid_fresh got=%h exp=%h", bus.grt_o, e); end
    advance(e);
  endtask

  task automatic test_illegal_port();
    logic [N*N-1:0] e;
    apply_reset();
    set_req(2, 1'b1, 6, 1'b1);
    step(e);
    checks++;
    if (bus.grt_o !== '0) begin failures++; $display("FAIL illegal_grt got=%h exp=0", bus.grt_o); end
    advance(e);
    set_req(2, 1'b0, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.err_o !== 1'b1) begin failures++; $display("FAIL illegal_err c=%0d got=%b exp=1", c, bus.err_o); end
      step(e);
      advance(e);
    end
    apply_reset();
    checks++;
    if (bus.err_o !== 1'b0) begin failures++; $display("FAIL illegal_err_clear got=%b exp=0", bus.err_o); end
  endtask

  task automatic test_random();
    logic [N*N-1:0] e;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 60) == 0);
      for (int i = 0; i < N; i++) begin
        set_req(i, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 40) == 0) ? 5 + $urandom_range(0, 2) : $urandom_range(0, N - 1),
                $urandom_range(0, 2) == 0);
        bus.rdy_i[i] = ($urandom_range(0, 3) != 0);
      end
      step(e);
      checks++;
      if (bus.grt_o !== e) begin failures++; $display("FAIL rand_grt c=%0d got=%h exp=%h", c, bus.grt_o, e); end
      advance(e);
      checks++;
      if (bus.lck_o !== m_lck_vec() || bus.dbg_rr_o !== m_rr_vec() || bus.err_o !== m_err) begin
        failures++;
        $display("FAIL rand_state c=%0d got lck=%h rr=%h err=%b exp lck=%h rr=%h err=%b",
                 c, bus.lck_o, bus.dbg_rr_o, bus.err_o, m_lck_vec(), m_rr_vec(), m_err);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fairness();
    test_wormhole();
    test_backpressure();
    test_bubble();
    test_reset_mid_packet();
    test_illegal_port();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
